// File: rtl/led_pattern_pkg.sv
// Shared mode/direction encodings and Gray-code helpers for led_pattern_gen.
// Defining LED_PATTERN_GRAY_EN turns mode 7 from HOLD into a Gray up-count.
package led_pattern_pkg;

   localparam int unsigned GRAY_MAX_W = 32;

   typedef enum logic [2:0] {
      MODE_UP     = 3'd0,
      MODE_DOWN   = 3'd1,
      MODE_SHL    = 3'd2,
      MODE_SHR    = 3'd3,
      MODE_ROL    = 3'd4,
      MODE_ROR    = 3'd5,
      MODE_BOUNCE = 3'd6,
`ifdef LED_PATTERN_GRAY_EN
      MODE_GRAY   = 3'd7
`else
      MODE_HOLD   = 3'd7
`endif
   } mode_e;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended inputs convert correctly: the leading zeros contribute nothing.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = '0;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
         b[GRAY_MAX_W-1-i] = b[GRAY_MAX_W-i] ^ g[GRAY_MAX_W-1-i];
      end
      return b;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler producing a registered one-cycle tick every
// CLK_HZ/STEP_HZ enabled cycles; reusable by other board demos.
module tick_prescaler #(
   parameter int unsigned CLK_HZ  = 50000000,
   parameter int unsigned STEP_HZ = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick_o
);

   localparam int unsigned PRESCALE = (CLK_HZ / STEP_HZ < 1) ? 1 : CLK_HZ / STEP_HZ;
   localparam int unsigned CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (enable) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// WIDTH-bit LED pattern register stepped by a prescaler tick in one of eight modes.
// Build option LED_PATTERN_GRAY_EN: mode 7 becomes Gray up-count (WIDTH <= 32).
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned CLK_HZ  = 50000000,
   parameter int unsigned STEP_HZ = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] cout,
   output logic             tick_o,
   output logic             wrap_o,
   output logic             dir_o
);

   logic             tick;
   logic [WIDTH-1:0] cout_q, cout_d, step_val;
   logic             dir_q, dir_d, step_dir;
   logic             wrap_q, wrap_d, step_wrap;
`ifdef LED_PATTERN_GRAY_EN
   logic [WIDTH-1:0] gray_bin;
`endif

   tick_prescaler #(
      .CLK_HZ  (CLK_HZ),
      .STEP_HZ (STEP_HZ)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick_o (tick)
   );

   always_comb begin
      step_val  = cout_q;
      step_dir  = dir_q;
      step_wrap = 1'b0;
`ifdef LED_PATTERN_GRAY_EN
      gray_bin  = '0;
`endif
      case (mode_e'(mode))
         MODE_UP: begin
            step_val  = cout_q + WIDTH'(1);
            step_wrap = &cout_q;
         end
         MODE_DOWN: begin
            step_val  = cout_q - WIDTH'(1);
            step_wrap = (cout_q == '0);
         end
         MODE_SHL: begin
            step_val  = {cout_q[WIDTH-2:0], 1'b0};
            step_wrap = cout_q[WIDTH-1];
         end
         MODE_SHR: begin
            step_val  = {1'b0, cout_q[WIDTH-1:1]};
            step_wrap = cout_q[0];
         end
         MODE_ROL: begin
            step_val  = {cout_q[WIDTH-2:0], cout_q[WIDTH-1]};
            step_wrap = cout_q[WIDTH-1];
         end
         MODE_ROR: begin
            step_val  = {cout_q[0], cout_q[WIDTH-1:1]};
            step_wrap = cout_q[0];
         end
         MODE_BOUNCE: begin
            // An empty register is reseeded rather than bounced, so the light never dies.
            if (cout_q == '0) begin
               step_val = WIDTH'(1);
            end else if (dir_q == DIR_LEFT && cout_q[WIDTH-1]) begin
               step_dir  = DIR_RIGHT;
               step_val  = {1'b0, cout_q[WIDTH-1:1]};
               step_wrap = 1'b1;
            end else if (dir_q == DIR_RIGHT && cout_q[0]) begin
               step_dir  = DIR_LEFT;
               step_val  = {cout_q[WIDTH-2:0], 1'b0};
               step_wrap = 1'b1;
            end else if (dir_q == DIR_LEFT) begin
               step_val = {cout_q[WIDTH-2:0], 1'b0};
            end else begin
               step_val = {1'b0, cout_q[WIDTH-1:1]};
            end
         end
`ifdef LED_PATTERN_GRAY_EN
         MODE_GRAY: begin
            gray_bin  = WIDTH'(gray2bin(GRAY_MAX_W'(cout_q)));
            step_val  = WIDTH'(bin2gray(GRAY_MAX_W'(gray_bin + WIDTH'(1))));
            step_wrap = &gray_bin;
         end
`else
         MODE_HOLD: begin
            step_val = cout_q;
         end
`endif
         default: begin
            step_val = cout_q;
         end
      endcase
   end

   // The registered tick is honoured even in the cycle enable drops.
   always_comb begin
      cout_d = cout_q;
      dir_d  = dir_q;
      wrap_d = 1'b0;
      if (load) begin
         cout_d = parallel_in;
         dir_d  = DIR_LEFT;
      end else if (tick) begin
         cout_d = step_val;
         dir_d  = step_dir;
         wrap_d = step_wrap;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cout_q <= '0;
         dir_q  <= DIR_LEFT;
         wrap_q <= 1'b0;
      end else begin
         cout_q <= cout_d;
         dir_q  <= dir_d;
         wrap_q <= wrap_d;
      end
   end

   assign cout   = cout_q;
   assign tick_o = tick;
   assign wrap_o = wrap_q;
   assign dir_o  = dir_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (WIDTH=8, PRESCALE=4); honours LED_PATTERN_GRAY_EN.
module tb_led_pattern_gen;
   import led_pattern_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [2:0] mode = 3'd0;
   logic       load = 1'b0;
   logic [7:0] parallel_in = 8'h00;
   logic [7:0] cout;
   logic       tick_o, wrap_o, dir_o;

   led_pattern_gen #(
      .WIDTH   (8),
      .CLK_HZ  (4),
      .STEP_HZ (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .mode        (mode),
      .load        (load),
      .parallel_in (parallel_in),
      .cout        (cout),
      .tick_o      (tick_o),
      .wrap_o      (wrap_o),
      .dir_o       (dir_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] cout;
      logic       wrap;
      logic       dir;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [7:0] c, input logic w, input logic d);
      exp_q.push_back('{cout: c, wrap: w, dir: d});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         cyc(1);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d expected steps left, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_tick();
      int t = 0;
      while (tick_o !== 1'b1 && t < 20) begin
         cyc(1);
         t++;
      end
      n_checks++;
      if (tick_o !== 1'b1) begin
         n_fail++;
         $display("FAIL tick_timeout: tick_o=%0b, required 1", tick_o);
      end
   endtask

   task automatic do_load(input logic [7:0] v, input logic [2:0] m);
      parallel_in = v;
      mode        = m;
      load        = 1'b1;
      push(v, 1'b0, 1'b1);
      cyc(1);
      load = 1'b0;
   endtask

   // Monitor: one expectation per step/load edge, plus tick period and idle wrap checks.
   initial begin
      logic p_reset, p_load, p_en, p_tick;
      int   en_cnt;
      exp_t e;
      p_reset = 1'b1; p_load = 1'b0; p_en = 1'b0; p_tick = 1'b0;
      en_cnt = 0;
      forever begin
         @(negedge clk);
         if (!p_reset && (p_tick || p_load)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_step: cout=%0h with no expectation queued", cout);
            end else begin
               e = exp_q.pop_front();
               check("cout", 32'(cout), 32'(e.cout));
               check("wrap_o", 32'(wrap_o), 32'(e.wrap));
               check("dir_o", 32'(dir_o), 32'(e.dir));
            end
         end else begin
            check("wrap_idle", 32'(wrap_o), 32'd0);
         end
         if (p_reset) en_cnt = 0;
         else if (p_en) en_cnt++;
         if (tick_o === 1'b1) begin
            check("tick_period", 32'(en_cnt), 32'd4);
            en_cnt = 0;
         end
         p_reset = reset;
         p_load  = load;
         p_en    = enable;
         p_tick  = tick_o;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      cyc(3);
      @(negedge clk);
      check("rst_cout", 32'(cout), 32'h00);
      check("rst_dir", 32'(dir_o), 32'd1);
      check("rst_tick", 32'(tick_o), 32'd0);
      check("rst_wrap", 32'(wrap_o), 32'd0);
      cyc(1);

      // Release and run UP from zero
      mode = MODE_UP;
      push(8'h01, 1'b0, 1'b1);
      push(8'h02, 1'b0, 1'b1);
      reset  = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("pre_tick_cout", 32'(cout), 32'h00);
         check("pre_tick_dir", 32'(dir_o), 32'd1);
      end
      wait_drain();

      // UP wrap, then DOWN wrap
      do_load(8'hFE, MODE_UP);
      push(8'hFF, 1'b0, 1'b1);
      push(8'h00, 1'b1, 1'b1);
      wait_drain();
      mode = MODE_DOWN;
      push(8'hFF, 1'b1, 1'b1);
      push(8'hFE, 1'b0, 1'b1);
      wait_drain();

      // Shifts and rotate right
      do_load(8'h81, MODE_SHL);
      push(8'h02, 1'b1, 1'b1);
      push(8'h04, 1'b0, 1'b1);
      wait_drain();
      mode = MODE_SHR;
      push(8'h02, 1'b0, 1'b1);
      push(8'h01, 1'b0, 1'b1);
      push(8'h00, 1'b1, 1'b1);
      wait_drain();
      do_load(8'h01, MODE_ROR);
      push(8'h80, 1'b1, 1'b1);
      push(8'h40, 1'b0, 1'b1);
      wait_drain();

      // Bounce across the full width and back
      do_load(8'h40, MODE_BOUNCE);
      push(8'h80, 1'b0, 1'b1);
      push(8'h40, 1'b1, 1'b0);
      push(8'h20, 1'b0, 1'b0);
      push(8'h10, 1'b0, 1'b0);
      push(8'h08, 1'b0, 1'b0);
      push(8'h04, 1'b0, 1'b0);
      push(8'h02, 1'b0, 1'b0);
      push(8'h01, 1'b0, 1'b0);
      push(8'h02, 1'b1, 1'b1);
      wait_drain();
      do_load(8'h00, MODE_BOUNCE);
      push(8'h01, 1'b0, 1'b1);
      push(8'h02, 1'b0, 1'b1);
      wait_drain();

      // Load coincident with a tick: step discarded
      wait_tick();
      do_load(8'hA5, MODE_ROL);
      push(8'h4B, 1'b1, 1'b1);
      push(8'h96, 1'b0, 1'b1);
      wait_drain();

      // Enable freeze mid-period
      mode = MODE_UP;
      push(8'h97, 1'b0, 1'b1);
      push(8'h98, 1'b0, 1'b1);
      wait_tick();
      cyc(1);
      enable = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("freeze_cout", 32'(cout), 32'h97);
         check("freeze_tick", 32'(tick_o), 32'd0);
         @(posedge clk);
         #1;
      end
      enable = 1'b1;
      wait_drain();

`ifdef LED_PATTERN_GRAY_EN
      do_load(8'h00, 3'd7);
      push(8'h01, 1'b0, 1'b1);
      push(8'h03, 1'b0, 1'b1);
      push(8'h02, 1'b0, 1'b1);
      push(8'h06, 1'b0, 1'b1);
      wait_drain();
      do_load(8'h80, 3'd7);
      push(8'h00, 1'b1, 1'b1);
      wait_drain();
`else
      mode = 3'd7;
      push(8'h98, 1'b0, 1'b1);
      push(8'h98, 1'b0, 1'b1);
      wait_drain();
`endif

      // Reset while bouncing right
      do_load(8'h80, MODE_BOUNCE);
      push(8'h40, 1'b1, 1'b0);
      wait_drain();
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      check("midrst_cout", 32'(cout), 32'h00);
      check("midrst_dir", 32'(dir_o), 32'd1);
      check("midrst_tick", 32'(tick_o), 32'd0);
      check("midrst_wrap", 32'(wrap_o), 32'd0);
      mode = MODE_UP;
      push(8'h01, 1'b0, 1'b1);
      wait_drain();
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the board-level 8-bit LED counter.
- A WIDTH-bit pattern register advances once per prescaler tick in one of several selectable modes: binary up/down count, shift, rotate, or bounce ("running light").
- Supports synchronous parallel load and provides a wrap/reversal event pulse.
- Sits between the board clock and the LED/7-seg drivers on DE0-class boards.

Parameters:
- WIDTH, 8: pattern/counter width in bits (min 2).
- CLK_HZ, 50000000: input clock frequency.
- STEP_HZ, 1: pattern step rate. PRESCALE = CLK_HZ/STEP_HZ (integer, min 1); prescaler width is clog2(PRESCALE).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = prescaler runs and steps are applied; 0 = freeze.
- mode  in  3  step mode (encoding below).
- load  in  1  active-high synchronous parallel load.
- parallel_in  in  WIDTH  load value.
- cout  out  WIDTH  pattern register.
- tick_o  out  1  one-cycle pulse on each prescaler step.
- wrap_o  out  1  one-cycle event pulse, coincident with the step that caused it.
- dir_o  out  1  bounce direction: 1 = left (toward MSB), 0 = right.

Behaviour:
- Reset (cycle after reset=1 sampled): cout=0, prescaler=0, tick_o=0, wrap_o=0, dir_o=1. Reset overrides load and enable.
- Prescaler:
  - Counts 0..PRESCALE-1 only while enable=1; holds its value while enable=0.
  - tick_o=1 for exactly one cycle in the cycle after the counter reaches PRESCALE-1. The counter returns to 0 on that same edge.
  - Period is exactly PRESCALE enabled cycles.
  - PRESCALE=1 gives tick_o=1 on every enabled cycle.
- Step rule: cout updates on the edge following a cycle with tick_o=1. Latency tick -> cout change = 1 clock. mode is sampled at that edge; mode changes between ticks have no other effect.
- Modes (all arithmetic modulo 2^WIDTH):
  - 0 UP: cout+1. wrap_o when all-ones -> 0.
  - 1 DOWN: cout-1. wrap_o when 0 -> all-ones.
  - 2 SHL: {cout[WIDTH-2:0],0}. wrap_o if the bit shifted out was 1.
  - 3 SHR: {0,cout[WIDTH-1:1]}. wrap_o if the bit shifted out was 1.
  - 4 ROL: {cout[WIDTH-2:0],cout[WIDTH-1]}. wrap_o if MSB was 1.
  - 5 ROR: {cout[0],cout[WIDTH-1:1]}. wrap_o if LSB was 1.
  - 6 BOUNCE:
    - If cout==0: load 1 (seed), no wrap.
    - Else if dir=1 and cout[WIDTH-1]=1: dir<=0, shift right, wrap_o=1.
    - Else if dir=0 and cout[0]=1: dir<=1, shift left, wrap_o=1.
    - Otherwise shift in dir (zero fill).
  - 7 HOLD: no change, no wrap (see Optional Feature).
- Load:
  - load=1 sets cout<=parallel_in and dir<=1 on the next edge, regardless of enable.
  - Load beats a simultaneous tick: the step is discarded and wrap_o=0.
  - The prescaler is not affected by load.
- enable=0: cout, dir and prescaler frozen; tick_o=0, wrap_o=0. A pending step in the same cycle that enable falls is still applied, because tick_o was already registered.
- Reset mid-operation: everything returns to reset values on the next edge; the first tick after reset comes PRESCALE enabled cycles later.

Optional Feature:
- Macro LED_PATTERN_GRAY_EN.
- Defined: mode 7 = GRAY up-count. cout <= bin2gray(gray2bin(cout)+1), computed combinationally with no extra state. wrap_o when gray2bin(cout) is all-ones.
- Undefined: mode 7 = HOLD as above, and no Gray logic is synthesised.

Decomposition:
- Package led_pattern_pkg:
  - Mode constants MODE_UP..MODE_HOLD/MODE_GRAY (3-bit).
  - DIR_LEFT/DIR_RIGHT.
  - bin2gray/gray2bin functions.
- Sub-module tick_prescaler (params CLK_HZ, STEP_HZ; ports clk, reset, enable, tick_o). It is reusable for other board demos.

Test Plan:
All scenarios use WIDTH=8, CLK_HZ=4, STEP_HZ=1 (PRESCALE=4).
- Reset/prescaler: hold reset 3 cycles, release, enable=1 -> tick_o pulses every 4th cycle (first after 4 cycles); cout=0, dir_o=1 before the first tick.
- UP wrap: load 8'hFE, mode 0 -> cout FF then 00 with wrap_o=1 on the 00 step; DOWN from 00 -> FF with wrap_o=1.
- BOUNCE: load 8'h40, mode 6 -> 80, then 40 (dir_o=0, wrap_o=1), ..., 01, then 02 (dir_o=1, wrap_o=1). cout=0 in mode 6 -> next step gives 01.
- Load vs tick: assert load with parallel_in=8'hA5 in the tick_o cycle, mode 4 -> cout=A5 (not rotated), wrap_o=0; next step gives 4B.
- Enable freeze: deassert enable mid-period for 10 cycles -> cout and prescaler unchanged, no tick_o; after re-enable the remaining count completes the period.
- GRAY (macro on): from 0, mode 7 -> 00,01,03,02,06..., wrap_o on 80 -> 00.
